// File: rtl/dma_controller.sv
// Block DMA engine: on cmd it requests the bus, then writes NBLK 64-bit blocks
// from the device into data memory, holding each block on the bus for MEM_LATENCY cycles.
module dma_controller #(
   parameter logic [15:0] BASE_ADDR   = 16'h01F4,
   parameter int          LENGTH      = 12,
   parameter int          MEM_LATENCY = 4
) (
   input  logic        Clk,
   input  logic        Reset_N,
   input  logic        cmd,
   input  logic        BG,
   output logic        BR,
   input  logic [63:0] dev_data,
   output logic [1:0]  dev_idx,
   output wire  [15:0] d_address,
   output wire  [63:0] d_data,
   output wire         d_writeM,
   output wire         d_readM,
   output logic        dma_end,
   output logic [1:0]  dbg_state
);

   localparam int NBLK  = LENGTH / 4;
   localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [1:0]       BLK_LAST = 2'(NBLK - 1);
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       blk_q, blk_d;
   logic [LAT_W-1:0] lat_q, lat_d;
   logic             br_q, br_d;
   logic             bus_en;
   logic [15:0]      addr;

   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         state_q <= IDLE;
         blk_q   <= 2'd0;
         lat_q   <= '0;
         br_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         blk_q   <= blk_d;
         lat_q   <= lat_d;
         br_q    <= br_d;
      end
   end

   always_comb begin
      state_d = state_q;
      blk_d   = blk_q;
      lat_d   = lat_q;
      unique case (state_q)
         IDLE: begin
            if (cmd) begin
               state_d = REQ;
               blk_d   = 2'd0;
               lat_d   = '0;
            end
         end
         REQ: begin
            if (BG) begin
               state_d = WRITE;
               lat_d   = '0;
            end
         end
         WRITE: begin
            // Losing the grant restarts the current block from its first cycle.
            if (!BG) begin
               state_d = REQ;
               lat_d   = '0;
            end else if (lat_q == LAT_LAST) begin
               if (blk_q == BLK_LAST) begin
                  state_d = DONE;
               end else begin
                  blk_d = blk_q + 2'd1;
                  lat_d = '0;
               end
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      br_d = (state_d == REQ) || (state_d == WRITE);
   end

   // The grant gates the drivers directly so the bus is released in the cycle BG drops.
   assign bus_en    = (state_q == WRITE) && BG;
   assign addr      = BASE_ADDR + {12'd0, blk_q, 2'b00};
   assign d_address = bus_en ? addr     : 16'hzzzz;
   assign d_data    = bus_en ? dev_data : {64{1'bz}};
   assign d_writeM  = bus_en ? 1'b1     : 1'bz;
   assign d_readM   = bus_en ? 1'b0     : 1'bz;

   assign BR        = br_q;
   assign dma_end   = (state_q == DONE);
   assign dev_idx   = blk_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_dma_controller.sv
// Self-checking bench for dma_controller: randomized transfers, grant loss,
// stray commands, mid-transfer reset and address wrap-around.
module tb_dma_controller;

   localparam logic [15:0] BASE = 16'h01F4;
   localparam int NBLK = 3;
   localparam int ML   = 4;

   logic        Clk;
   logic        rst_n;
   logic        cmd, bg;
   logic        br, dma_end;
   logic [1:0]  dev_idx, dbg_state;
   logic [63:0] dev_data;
   logic [63:0] blk_mem [4];
   // Pull resistors make an undriven bus visible: address/data/readM float high, writeM low.
   tri1  [15:0] d_address;
   tri1  [63:0] d_data;
   tri0         d_writeM;
   tri1         d_readM;

   logic        cmd2, bg2;
   logic        br2, dma_end2;
   logic [1:0]  dev_idx2, dbg_state2;
   logic [63:0] dev_data2;
   tri1  [15:0] d_address2;
   tri1  [63:0] d_data2;
   tri0         d_writeM2;
   tri1         d_readM2;

   int n_tests = 0;
   int n_fail  = 0;

   assign dev_data  = blk_mem[dev_idx];
   assign dev_data2 = {48'h0, 14'h0, dev_idx2};

   dma_controller dut (
      .Clk(Clk), .Reset_N(rst_n), .cmd(cmd), .BG(bg), .BR(br),
      .dev_data(dev_data), .dev_idx(dev_idx), .d_address(d_address),
      .d_data(d_data), .d_writeM(d_writeM), .d_readM(d_readM),
      .dma_end(dma_end), .dbg_state(dbg_state)
   );

   dma_controller #(.BASE_ADDR(16'hFFFC), .LENGTH(8), .MEM_LATENCY(4)) dut_wrap (
      .Clk(Clk), .Reset_N(rst_n), .cmd(cmd2), .BG(bg2), .BR(br2),
      .dev_data(dev_data2), .dev_idx(dev_idx2), .d_address(d_address2),
      .d_data(d_data2), .d_writeM(d_writeM2), .d_readM(d_readM2),
      .dma_end(dma_end2), .dbg_state(dbg_state2)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog");
   end

   // Bus released: pulled values visible and no strobe.
   task automatic check_idle_bus(input string tag);
      n_tests++;
      if (d_writeM !== 1'b0 || d_readM !== 1'b1 || d_address !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL %s bus_released: got wr=%b rd=%b addr=%h, want wr=0(undriven) rd=1(undriven) addr=ffff",
                  tag, d_writeM, d_readM, d_address);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cmd = 1'b0; bg = 1'b0; cmd2 = 1'b0; bg2 = 1'b1;
      for (int i = 0; i < 4; i++) blk_mem[i] = 64'h0;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      n_tests++;
      if (br !== 1'b0 || dma_end !== 1'b0 || dev_idx !== 2'd0 || dbg_state !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got br=%b end=%b idx=%0d st=%0d, want 0 0 0 0", br, dma_end, dev_idx, dbg_state);
      end
      check_idle_bus("reset");
      @(posedge Clk); #1 rst_n = 1'b1;
      @(negedge Clk);
      n_tests++;
      if (br !== 1'b0 || dbg_state !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_release: got br=%b st=%0d, want br=0 st=0", br, dbg_state);
      end
   endtask

   // One transfer. drop_at / cmd_at / rst_at name a write-cycle ordinal (-1 = never).
   task automatic run_xfer(input int bg_wait, input int drop_at, input int cmd_at,
                           input int rst_at, input bit done_cmd, input string tag);
      int j;
      int w;
      int blk;
      for (int i = 0; i < 4; i++) blk_mem[i] = {$urandom, $urandom};
      @(posedge Clk); #1 cmd = 1'b1; bg = 1'b0;
      @(negedge Clk);
      n_tests++;
      if (br !== 1'b0) begin n_fail++; $display("FAIL %s br_idle: got %b want 0", tag, br); end
      @(posedge Clk); #1 cmd = 1'b0;
      @(negedge Clk);
      n_tests++;
      if (br !== 1'b1) begin n_fail++; $display("FAIL %s br_rise: got %b want 1", tag, br); end
      check_idle_bus(tag);
      for (int i = 0; i < bg_wait; i++) begin
         @(posedge Clk); #1;
         @(negedge Clk);
         n_tests++;
         if (br !== 1'b1) begin n_fail++; $display("FAIL %s br_wait: got %b want 1", tag, br); end
         check_idle_bus(tag);
      end
      @(posedge Clk); #1 bg = 1'b1;
      @(negedge Clk);
      check_idle_bus(tag);
      j = 0;
      w = 0;
      while (j < NBLK * ML && w < 100) begin
         @(posedge Clk); #1;
         cmd = (w == cmd_at);
         blk = j / ML;
         if (w == drop_at) begin
            bg = 1'b0;
            @(negedge Clk);
            n_tests++;
            if (br !== 1'b1) begin n_fail++; $display("FAIL %s br_drop: got %b want 1", tag, br); end
            check_idle_bus(tag);
            @(posedge Clk); #1 bg = 1'b1; cmd = 1'b0;
            @(negedge Clk);
            n_tests++;
            if (dbg_state !== 2'd1 || br !== 1'b1) begin
               n_fail++;
               $display("FAIL %s regrant_req: got st=%0d br=%b want st=1 br=1", tag, dbg_state, br);
            end
            check_idle_bus(tag);
            j = blk * ML;
            w++;
            continue;
         end
         @(negedge Clk);
         n_tests++;
         if (d_writeM !== 1'b1 || d_readM !== 1'b0 || d_address !== BASE + 16'(4 * blk) ||
             d_data !== blk_mem[blk] || dev_idx !== 2'(blk) || br !== 1'b1 || dma_end !== 1'b0) begin
            n_fail++;
            $display("FAIL %s write_cyc%0d: got wr=%b rd=%b addr=%h data=%h idx=%0d br=%b end=%b, want 1 0 %h %h %0d 1 0",
                     tag, w, d_writeM, d_readM, d_address, d_data, dev_idx, br, dma_end,
                     BASE + 16'(4 * blk), blk_mem[blk], blk);
         end
         if (w == rst_at) begin
            #1 rst_n = 1'b0;
            #1;
            n_tests++;
            if (br !== 1'b0 || dma_end !== 1'b0 || dev_idx !== 2'd0 || dbg_state !== 2'd0) begin
               n_fail++;
               $display("FAIL %s async_reset: got br=%b end=%b idx=%0d st=%0d want 0 0 0 0",
                        tag, br, dma_end, dev_idx, dbg_state);
            end
            check_idle_bus(tag);
            @(posedge Clk); #1 rst_n = 1'b1; cmd = 1'b0;
            repeat (3) begin
               @(negedge Clk);
               n_tests++;
               if (br !== 1'b0 || dbg_state !== 2'd0) begin
                  n_fail++;
                  $display("FAIL %s post_reset_idle: got br=%b st=%0d want 0 0", tag, br, dbg_state);
               end
            end
            return;
         end
         j++;
         w++;
      end
      n_tests++;
      if (w >= 100) begin n_fail++; $display("FAIL %s write_budget: got %0d cycles want <100", tag, w); end
      @(posedge Clk); #1 cmd = done_cmd;
      @(negedge Clk);
      n_tests++;
      if (dma_end !== 1'b1 || br !== 1'b0) begin
         n_fail++;
         $display("FAIL %s done_pulse: got end=%b br=%b want end=1 br=0", tag, dma_end, br);
      end
      check_idle_bus(tag);
      @(posedge Clk); #1 cmd = 1'b0;
      repeat (3) begin
         @(negedge Clk);
         n_tests++;
         if (dma_end !== 1'b0 || br !== 1'b0 || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL %s after_done: got end=%b br=%b st=%0d want 0 0 0", tag, dma_end, br, dbg_state);
         end
         check_idle_bus(tag);
         @(posedge Clk); #1;
      end
   endtask

   task automatic test_basic();
      run_xfer(0, -1, -1, -1, 1'b0, "basic");
   endtask

   task automatic test_bg_wait();
      run_xfer(10, -1, -1, -1, 1'b0, "bg_wait");
   endtask

   task automatic test_bg_drop();
      run_xfer(0, ML + 1, -1, -1, 1'b0, "bg_drop");
   endtask

   task automatic test_cmd_ignored();
      run_xfer(0, -1, 5, -1, 1'b1, "cmd_ignored");
   endtask

   task automatic test_reset_mid();
      run_xfer(0, -1, -1, ML + 1, 1'b0, "reset_mid");
      run_xfer(0, -1, -1, -1, 1'b0, "after_reset");
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         int drop;
         drop = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, NBLK * ML - 1));
         run_xfer(int'($urandom_range(0, 5)), drop, int'($urandom_range(0, 11)), -1,
                  1'($urandom_range(0, 1)), "random");
      end
   endtask

   task automatic test_wrap();
      int k;
      logic [15:0] exp_addr;
      @(posedge Clk); #1 cmd2 = 1'b1; bg2 = 1'b1;
      @(posedge Clk); #1 cmd2 = 1'b0;
      k = 0;
      @(negedge Clk);
      while (d_writeM2 !== 1'b1 && k < 10) begin
         @(negedge Clk);
         k++;
      end
      n_tests++;
      if (k >= 10) begin n_fail++; $display("FAIL wrap_start: got no write strobe within 10 cycles, want one"); end
      for (int i = 0; i < 8; i++) begin
         exp_addr = (i < 4) ? 16'hFFFC : 16'h0000;
         n_tests++;
         if (d_writeM2 !== 1'b1 || d_address2 !== exp_addr || dma_end2 !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_write%0d: got wr=%b addr=%h end=%b want 1 %h 0", i, d_writeM2, d_address2, dma_end2, exp_addr);
         end
         @(negedge Clk);
      end
      n_tests++;
      if (dma_end2 !== 1'b1 || d_writeM2 !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_done: got end=%b wr=%b want end=1 wr=0", dma_end2, d_writeM2);
      end
      @(negedge Clk);
      n_tests++;
      if (dma_end2 !== 1'b0 || br2 !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_idle: got end=%b br=%b want 0 0", dma_end2, br2);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bg_wait();
      test_bg_drop();
      test_cmd_ignored();
      test_reset_mid();
      test_random();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
